// File: rtl/serializer_piso.sv
// Parallel-in/serial-out serializer: a WIDTH-bit word accepted over valid/ready is shifted out one bit per BIT_CYCLES clocks.
// Outputs are registered from next-state values; in_ready reopens in the final bit-cycle so words stream with no gap.
module serializer_piso #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             ser_last
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_MAX = CW'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] word, word_nx;
  logic [BW-1:0]    bit_idx, bit_idx_nx, sel;
  logic [CW-1:0]    cyc, cyc_nx;
  logic             cyc_end, end_slot, accept;
  logic             out_nx, frame_nx, last_nx;

  // With one cycle per bit the cycle counter is held at zero and optimises away.
  assign cyc_end  = (BIT_CYCLES == 1) || (cyc == CYC_MAX);
  assign end_slot = (state == SHIFT) && (bit_idx == BIT_MAX) && cyc_end;
  assign in_ready = (state == IDLE) || end_slot;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nx   = state;
    word_nx    = word;
    bit_idx_nx = bit_idx;
    cyc_nx     = cyc;
    if (accept) begin
      state_nx   = SHIFT;
      word_nx    = in_data;
      bit_idx_nx = '0;
      cyc_nx     = '0;
    end else if (state == SHIFT) begin
      if (end_slot) begin
        state_nx   = IDLE;
        bit_idx_nx = '0;
        cyc_nx     = '0;
      end else if (cyc_end) begin
        cyc_nx     = '0;
        bit_idx_nx = bit_idx + BW'(1);
      end else begin
        cyc_nx = cyc + CW'(1);
      end
    end
  end

  // Outputs are computed from the next state so the first bit appears right after the accept edge.
  always_comb begin
    sel      = MSB_FIRST ? (BIT_MAX - bit_idx_nx) : bit_idx_nx;
    out_nx   = IDLE_LEVEL;
    frame_nx = 1'b0;
    last_nx  = 1'b0;
    if (state_nx == SHIFT) begin
      out_nx   = word_nx[sel];
      frame_nx = 1'b1;
      last_nx  = (bit_idx_nx == BIT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      bit_idx   <= '0;
      cyc       <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_frame <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      word      <= word_nx;
      bit_idx   <= bit_idx_nx;
      cyc       <= cyc_nx;
      ser_out   <= out_nx;
      ser_frame <= frame_nx;
      ser_last  <= last_nx;
    end
  end

endmodule

// File: tb/tb_serializer_piso.sv
// Three serializer configurations run side by side, each checked every cycle against a queue of expected serial slots.
module tb_serializer_piso;

  logic       clk = 1'b0;
  logic       rst_n;
  int         mode = 0;          // 0 quiet, 1 directed words, 2 random traffic
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] mid_mon;
  logic       dir_check = 1'b0;
  logic       found;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_cfg
    localparam int W   = (g == 2) ? 2 : 4;
    localparam int BC  = (g == 1) ? 3 : 1;
    localparam bit MSB = (g != 0);
    localparam bit IDL = (g == 2);
    localparam int N   = (g == 2) ? 4 : 3;

    logic         v = 1'b0;
    logic [W-1:0] d = '0;
    logic         rdy, so, sf, sl;
    logic [2:0]   exp_q[$];      // {ser_out, ser_frame, ser_last} per upcoming cycle
    logic         acc = 1'b0;
    logic [W-1:0] acc_word = '0;
    logic [3:0]   dlist[4];
    logic         gap[4];
    int           di = 0;
    int           gap_cnt = 0;
    logic         mid_flag = 1'b0;

    serializer_piso #(
      .WIDTH(W), .BIT_CYCLES(BC), .MSB_FIRST(MSB), .IDLE_LEVEL(IDL)
    ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(v), .in_ready(rdy), .in_data(d),
      .ser_out(so), .ser_frame(sf), .ser_last(sl)
    );

    assign mid_mon[g] = mid_flag;

    initial begin
      if (g == 0) begin
        dlist = '{4'b1010, 4'h3, 4'hC, 4'h0};
        gap   = '{1'b1, 1'b0, 1'b1, 1'b0};
      end else if (g == 1) begin
        dlist = '{4'b1100, 4'b0110, 4'b1001, 4'h0};
        gap   = '{1'b1, 1'b0, 1'b1, 1'b0};
      end else begin
        dlist = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
        gap   = '{1'b1, 1'b0, 1'b0, 1'b1};
      end
    end

    // Compare the current cycle, then drive inputs for the coming edge.
    always @(negedge clk) begin
      logic [2:0] e;
      e = (exp_q.size() > 0) ? exp_q[0] : {IDL, 2'b00};
      check($sformatf("c%0d_ser_out", g),   32'(so),  32'(e[2]));
      check($sformatf("c%0d_ser_frame", g), 32'(sf),  32'(e[1]));
      check($sformatf("c%0d_ser_last", g),  32'(sl),  32'(e[0]));
      check($sformatf("c%0d_in_ready", g),  32'(rdy), 32'(exp_q.size() <= 1));
      if (!rst_n || mode == 0) begin
        v = 1'b0;
      end else if (mode == 1) begin
        if (gap_cnt > 0) begin
          v = 1'b0;
          gap_cnt--;
        end else if (di < N) begin
          v = 1'b1;
          d = dlist[di][W-1:0];
        end else begin
          v = 1'b0;
        end
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end
      acc      = rst_n && v && (exp_q.size() <= 1);
      acc_word = d;
      if (acc && mode == 1) begin
        if (gap[di]) gap_cnt = W * BC + 2;
        di++;
      end
    end

    // Retire the slot that just ended and queue a freshly accepted word.
    always @(posedge clk) begin
      if (rst_n) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
          for (int b = 0; b < W; b++)
            for (int c = 0; c < BC; c++)
              exp_q.push_back({MSB ? acc_word[W-1-b] : acc_word[b], 1'b1, b == W - 1});
        end
        acc      = 1'b0;
        mid_flag = (exp_q.size() == 2 * BC);
      end
    end

    always @(negedge rst_n) begin
      exp_q.delete();
      acc      = 1'b0;
      mid_flag = 1'b0;
      #1;
      check($sformatf("c%0d_rst_ser_out", g),   32'(so),  32'(IDL));
      check($sformatf("c%0d_rst_ser_frame", g), 32'(sf),  32'd0);
      check($sformatf("c%0d_rst_ser_last", g),  32'(sl),  32'd0);
      check($sformatf("c%0d_rst_in_ready", g),  32'(rdy), 32'd1);
    end

    always @(posedge dir_check) check($sformatf("c%0d_directed_words", g), 32'(di), 32'(N));
  end

  initial begin
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    mode = 1;
    repeat (90) @(posedge clk);
    mode = 0;
    repeat (15) @(posedge clk);
    #1 dir_check = 1'b1;

    mode = 2;
    repeat (300) @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #3;
      if (mid_mon[0]) found = 1'b1;
    end
    check("mid_word_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (1500) @(posedge clk);
    mode = 0;
    repeat (20) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serializer_piso.md
# serializer_piso

Parametrised parallel-in/serial-out serializer that supersedes the fixed 4-bit load/shift register chain. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it onto a single serial line. Bit order, bit period and idle line level are configurable. Back-to-back words stream with no idle gap. It sits between a parallel producer (register bank, FIFO or counter) and a serial consumer (LED, pin or downstream deserializer).

## Interface
- WIDTH, 4, word width in bits; legal range is 2 or more.
- BIT_CYCLES, 1, clock cycles each bit is held on ser_out; legal range is 1 or more.
- MSB_FIRST, 0, 0 shifts bit 0 first, 1 shifts bit WIDTH-1 first.
- IDLE_LEVEL, 0, value driven on ser_out when no word is being shifted.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  serializer can take a word this cycle; combinational.
- in_data  input  WIDTH  parallel word; sampled only on an accept edge.
- ser_out  output  1  serial data; registered.
- ser_frame  output  1  high while ser_out carries a data bit; registered.
- ser_last  output  1  high for the full duration of the final bit of a word; registered.

## Operation
- State machine has two states.
  - IDLE: in_ready=1, ser_out=IDLE_LEVEL, ser_frame=0, ser_last=0.
  - SHIFT: the current bit is driven on ser_out.
- Internal counters:
  - bit_idx runs 0..WIDTH-1, width clog2(WIDTH).
  - cyc runs 0..BIT_CYCLES-1, width clog2(BIT_CYCLES), or no counter when BIT_CYCLES=1.
  - Both counters wrap to 0 after their maximum value.
- Accept occurs when in_valid=1 and in_ready=1 at a rising edge.
  - in_data is copied into the shift register.
  - bit_idx=0, cyc=0, state becomes SHIFT.
- Bit output:
  - With MSB_FIRST=0, ser_out shows word bit bit_idx.
  - With MSB_FIRST=1, ser_out shows word bit WIDTH-1-bit_idx.
  - Either a shift register or an indexed mux is an acceptable implementation, provided the observable output matches.
- Advance rule:
  - cyc increments every cycle.
  - When cyc=BIT_CYCLES-1, cyc wraps and bit_idx increments.
- The end slot is the cycle with bit_idx=WIDTH-1 and cyc=BIT_CYCLES-1.
- in_ready = (state==IDLE) or (state==SHIFT and in end slot).
  - If an accept happens in the end slot, the next word's first bit follows immediately.
  - The state stays SHIFT, ser_frame stays 1, and there is no idle cycle.
  - If there is no accept in the end slot, the next cycle returns to IDLE.
- in_ready does not depend on in_valid, so there is no combinational loop.
- The producer may hold in_valid high indefinitely; in_data may change freely except on the accept edge.

## Timing
- Reset values: ser_out=IDLE_LEVEL, ser_frame=0, ser_last=0, state=IDLE, counters=0. in_ready=1 while in reset.
- Latency: accept at edge k puts the first bit on ser_out after edge k, i.e. visible during cycle k+1.
- Word duration is exactly WIDTH*BIT_CYCLES cycles with ser_frame=1.
- Sustained throughput is one word per WIDTH*BIT_CYCLES cycles with in_valid held high.
- ser_last rises with the first cycle of the final bit and falls after the end slot.
  - In back-to-back streaming, ser_last drops for the new word's first bit.
- Reset asserted mid-word forces all outputs to their reset values immediately, asynchronously.
  - The partial word is discarded, not resumed.
- Deasserting in_valid during SHIFT has no effect on the word in flight.
- WIDTH=2 and BIT_CYCLES=1 are legal corner configurations and must still give gap-free streaming.

## Test plan
- Reset: hold rst_n=0, toggle clk. Required: ser_out=IDLE_LEVEL, ser_frame=0, ser_last=0, in_ready=1. Release reset with in_valid=0 for 5 cycles; outputs stay unchanged.
- LSB-first single word: WIDTH=4, BIT_CYCLES=1, MSB_FIRST=0, accept in_data=4'b1010.
  - Required: ser_out=0,1,0,1 on the next 4 cycles.
  - ser_frame=1 for exactly those 4 cycles; ser_last=1 on the 4th cycle only.
  - Then IDLE with ser_out=0.
- MSB-first with stretched bits: MSB_FIRST=1, BIT_CYCLES=3, accept 4'b1100.
  - Required: ser_out=1,1,1,1,1,1,0,0,0,0,0,0 over 12 cycles.
  - in_ready=0 for the first 11 cycles, 1 in the 12th.
- Back-to-back streaming: in_valid held high with 4'h3 then 4'hC, LSB first, BIT_CYCLES=1.
  - Required: ser_out=1,1,0,0,0,0,1,1 with ser_frame continuously 1 for 8 cycles.
  - Accepts occur on edges 0 and 4.
  - ser_last=1 on cycles 4 and 8.
- Reset mid-word: assert rst_n=0 asynchronously during bit 2 of a word.
  - Required: outputs reach reset values before the next clk edge.
  - After release, the next accepted word serializes fully from bit 0.
- Idle level and width corner: WIDTH=2, IDLE_LEVEL=1, accept 2'b00.
  - Required: ser_out=1 (idle), then 0,0, then 1.
  - ser_frame is high for exactly 2 cycles.
